// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
//
// Physical-register free list for a renaming front end. Free physical tags
// live in a D-entry circular buffer (D = N_PHYS - N_ARCH). Decode pops tags
// from the head. Retire pushes the previous mapping of each retiring
// destination at the tail. arch_head tracks the head position as seen by
// committed state only, so an interrupt can roll the speculative head back.
//
// Ports
//   clock        : single clock, all state changes on posedge
//   reset        : asynchronous, active-low
//   alloc_en     : decode consumes the head tag this cycle
//   alloc_valid  : head tag is available (free_count != 0)
//   alloc_tag    : physical tag at the head
//   retire_en    : retire commits one instruction this cycle
//   retire_t_old : previous mapping of the retiring destination (0 = none)
//   interrupt    : squash all speculative allocations
//   free_count   : number of free tags, 0..D
//   overflow_err : sticky, set when a push hits a full list
//
// Handshake: alloc_valid/alloc_tag act as valid/data and alloc_en as ready.
// A tag transfers only on a cycle where alloc_valid && alloc_en && !interrupt
// are all true at the clock edge. alloc_en while alloc_valid is low has no
// effect. All outputs come from registered state, so an alloc and a push in
// the same cycle never bypass into each other.
// -----------------------------------------------------------------------------
module free_list #(
    parameter int N_PHYS = 64,
    parameter int N_ARCH = 32,
    parameter int TW     = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          alloc_en,
    output logic          alloc_valid,
    output logic [TW-1:0] alloc_tag,
    input  logic          retire_en,
    input  logic [TW-1:0] retire_t_old,
    input  logic          interrupt,
    output logic [TW-1:0] free_count,
    output logic          overflow_err
);

    localparam int D  = N_PHYS - N_ARCH;
    localparam int DW = $clog2(D);
    // Each pointer carries an extra wrap bit. A full list and an empty list
    // then differ in tail - head.
    localparam int PW = DW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] arch_head;
    logic [TW-1:0] entries [D];

    logic [PW-1:0] count_w;
    logic          full;
    logic          empty;
    logic          has_dest;
    logic          push;
    logic          pop;
    logic [PW-1:0] arch_head_nxt;

    assign count_w  = tail - head;
    assign full     = (count_w == PW'(D));
    assign empty    = (count_w == '0);
    assign has_dest = retire_en && (retire_t_old != '0);
    assign push     = has_dest && !full;
    assign pop      = alloc_en && !empty && !interrupt;

    // The retiring instruction's own tag was allocated at arch_head. Any
    // retire with a destination therefore moves arch_head, even if the
    // push of t_old is dropped.
    assign arch_head_nxt = has_dest ? arch_head + PW'(1) : arch_head;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head         <= '0;
            arch_head    <= '0;
            tail         <= PW'(D);
            overflow_err <= 1'b0;
            for (int i = 0; i < D; i++) begin
                entries[i] <= TW'(N_ARCH + i);
            end
        end else begin
            arch_head <= arch_head_nxt;

            // On an interrupt, head jumps to the committed position and
            // includes a retire in the same cycle.
            if (interrupt) begin
                head <= arch_head_nxt;
            end else if (pop) begin
                head <= head + PW'(1);
            end

            if (push) begin
                entries[tail[DW-1:0]] <= retire_t_old;
                tail                  <= tail + PW'(1);
            end

            if (has_dest && full) begin
                overflow_err <= 1'b1;
            end
        end
    end

    assign alloc_valid = !empty;
    assign alloc_tag   = entries[head[DW-1:0]];
    assign free_count  = TW'(count_w);

endmodule

// File: tb/tb_free_list.sv
// -----------------------------------------------------------------------------
// tb_free_list
//
// Directed bench for free_list. The bench changes inputs 1 ns after a rising
// edge and samples outputs at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_free_list;

    logic       clock;
    logic       reset;
    logic       alloc_en;
    logic       alloc_valid;
    logic [5:0] alloc_tag;
    logic       retire_en;
    logic [5:0] retire_t_old;
    logic       interrupt;
    logic [5:0] free_count;
    logic       overflow_err;

    int n_checks;
    int n_fail;

    free_list #(.N_PHYS(64), .N_ARCH(32), .TW(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .alloc_en     (alloc_en),
        .alloc_valid  (alloc_valid),
        .alloc_tag    (alloc_tag),
        .retire_en    (retire_en),
        .retire_t_old (retire_t_old),
        .interrupt    (interrupt),
        .free_count   (free_count),
        .overflow_err (overflow_err)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_en     = 1'b0;
        retire_en    = 1'b0;
        retire_t_old = '0;
        interrupt    = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // scenarios
    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (alloc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_valid: got %0d expected 1", alloc_valid);
        end
        n_checks++;
        if (alloc_tag !== 6'd32) begin
            n_fail++;
            $display("FAIL reset_tag: got %0d expected 32", alloc_tag);
        end
        n_checks++;
        if (free_count !== 6'd32) begin
            n_fail++;
            $display("FAIL reset_count: got %0d expected 32", free_count);
        end
        n_checks++;
        if (overflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %0d expected 0", overflow_err);
        end
    endtask

    // 32 allocs drain the list. A 33rd alloc is ignored. Then a push arrives
    // together with an alloc on the empty list.
    task automatic test_drain_and_empty_push();
        apply_reset();
        for (int i = 0; i < 32; i++) begin
            n_checks++;
            if (alloc_tag !== 6'(32 + i)) begin
                n_fail++;
                $display("FAIL drain_tag[%0d]: got %0d expected %0d", i, alloc_tag, 32 + i);
            end
            alloc_en = 1'b1;
            tick();
        end
        alloc_en = 1'b0;
        n_checks++;
        if (free_count !== 6'd0 || alloc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_empty: got count=%0d valid=%0d expected count=0 valid=0",
                     free_count, alloc_valid);
        end
        alloc_en = 1'b1;
        tick();
        alloc_en = 1'b0;
        n_checks++;
        if (free_count !== 6'd0 || alloc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_extra_alloc: got count=%0d valid=%0d expected 0/0",
                     free_count, alloc_valid);
        end
        // empty list: push 5 plus alloc, alloc must be rejected
        alloc_en     = 1'b1;
        retire_en    = 1'b1;
        retire_t_old = 6'd5;
        tick();
        idle_inputs();
        n_checks++;
        if (free_count !== 6'd1) begin
            n_fail++;
            $display("FAIL empty_push_count: got %0d expected 1", free_count);
        end
        n_checks++;
        if (alloc_tag !== 6'd5 || alloc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_push_tag: got tag=%0d valid=%0d expected tag=5 valid=1",
                     alloc_tag, alloc_valid);
        end
    endtask

    // Alloc 32,33,34, retire with t_old=7, then interrupt.
    task automatic test_interrupt_reclaim();
        apply_reset();
        alloc_en = 1'b1;
        repeat (3) tick();
        alloc_en = 1'b0;
        n_checks++;
        if (free_count !== 6'd29 || alloc_tag !== 6'd35) begin
            n_fail++;
            $display("FAIL reclaim_alloc3: got count=%0d tag=%0d expected 29/35", free_count, alloc_tag);
        end
        retire_en    = 1'b1;
        retire_t_old = 6'd7;
        tick();
        idle_inputs();
        n_checks++;
        if (free_count !== 6'd30) begin
            n_fail++;
            $display("FAIL reclaim_retire: got %0d expected 30", free_count);
        end
        interrupt = 1'b1;
        alloc_en  = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (free_count !== 6'd32 || alloc_tag !== 6'd33) begin
            n_fail++;
            $display("FAIL reclaim_interrupt: got count=%0d tag=%0d expected 32/33", free_count, alloc_tag);
        end
    endtask

    // Interrupt and retire with t_old=9 in the same cycle. Then walk the
    // head round to index 0 to confirm that entry holds 9.
    task automatic test_interrupt_with_retire();
        apply_reset();
        alloc_en = 1'b1;
        repeat (2) tick();
        alloc_en     = 1'b0;
        interrupt    = 1'b1;
        retire_en    = 1'b1;
        retire_t_old = 6'd9;
        tick();
        idle_inputs();
        n_checks++;
        if (free_count !== 6'd32 || alloc_tag !== 6'd33) begin
            n_fail++;
            $display("FAIL int_retire: got count=%0d tag=%0d expected 32/33", free_count, alloc_tag);
        end
        alloc_en = 1'b1;
        repeat (31) tick();
        alloc_en = 1'b0;
        n_checks++;
        if (alloc_tag !== 6'd9 || free_count !== 6'd1) begin
            n_fail++;
            $display("FAIL int_retire_entry: got tag=%0d count=%0d expected 9/1", alloc_tag, free_count);
        end
    endtask

    // A push into a full list sets the sticky overflow flag and is dropped.
    task automatic test_overflow();
        apply_reset();
        retire_en    = 1'b1;
        retire_t_old = 6'd12;
        tick();
        idle_inputs();
        n_checks++;
        if (overflow_err !== 1'b1 || free_count !== 6'd32) begin
            n_fail++;
            $display("FAIL overflow_set: got ovf=%0d count=%0d expected 1/32", overflow_err, free_count);
        end
        n_checks++;
        if (alloc_tag !== 6'd32) begin
            n_fail++;
            $display("FAIL overflow_tag: got %0d expected 32", alloc_tag);
        end
        alloc_en = 1'b1;
        repeat (4) tick();
        alloc_en = 1'b0;
        n_checks++;
        if (overflow_err !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: got %0d expected 1", overflow_err);
        end
        apply_reset();
        n_checks++;
        if (overflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_cleared: got %0d expected 0", overflow_err);
        end
    endtask

    // An alloc and a push in the same cycle on a non-empty list.
    task automatic test_back_to_back();
        apply_reset();
        alloc_en = 1'b1;
        tick();
        retire_en    = 1'b1;
        retire_t_old = 6'd7;
        tick();
        idle_inputs();
        n_checks++;
        if (free_count !== 6'd31 || alloc_tag !== 6'd34) begin
            n_fail++;
            $display("FAIL b2b: got count=%0d tag=%0d expected 31/34", free_count, alloc_tag);
        end
    endtask

    // t_old=0 changes nothing. An asynchronous reset in mid-stream restores
    // the reset outputs at once.
    task automatic test_no_dest_and_async_reset();
        apply_reset();
        alloc_en = 1'b1;
        repeat (3) tick();
        alloc_en     = 1'b0;
        retire_en    = 1'b1;
        retire_t_old = 6'd0;
        tick();
        idle_inputs();
        n_checks++;
        if (free_count !== 6'd29 || alloc_tag !== 6'd35) begin
            n_fail++;
            $display("FAIL no_dest: got count=%0d tag=%0d expected 29/35", free_count, alloc_tag);
        end
        // t_old=0 must not move arch_head, so an interrupt returns head to 0.
        interrupt = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (free_count !== 6'd32 || alloc_tag !== 6'd32) begin
            n_fail++;
            $display("FAIL no_dest_arch: got count=%0d tag=%0d expected 32/32", free_count, alloc_tag);
        end
        alloc_en = 1'b1;
        repeat (5) tick();
        retire_en    = 1'b1;
        retire_t_old = 6'd3;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (alloc_valid !== 1'b1 || alloc_tag !== 6'd32 || free_count !== 6'd32 || overflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%0d tag=%0d count=%0d ovf=%0d expected 1/32/32/0",
                     alloc_valid, alloc_tag, free_count, overflow_err);
        end
        tick();
        idle_inputs();
        reset = 1'b1;
        tick();
        n_checks++;
        if (free_count !== 6'd32 || alloc_tag !== 6'd32) begin
            n_fail++;
            $display("FAIL async_reset_release: got count=%0d tag=%0d expected 32/32", free_count, alloc_tag);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        idle_inputs();
        test_reset();
        test_drain_and_empty_push();
        test_interrupt_reclaim();
        test_interrupt_with_retire();
        test_overflow();
        test_back_to_back();
        test_no_dest_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter N_PHYS, default 64, number of physical registers.
REQ-002 SHALL have parameter N_ARCH, default 32, number of architectural registers; free-list depth D = N_PHYS - N_ARCH (32).
REQ-003 SHALL have parameter TW, default 6, tag width, equal to log2(N_PHYS).
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on posedge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port alloc_en, input, 1: the decode stage consumes the head tag this cycle, used as the map-table write tag.
REQ-007 SHALL have port alloc_valid, output, 1: the head tag is available (free_count != 0).
REQ-008 SHALL have port alloc_tag, output, TW: the physical tag at the head.
REQ-009 SHALL have port retire_en, input, 1: the retire stage commits one instruction this cycle.
REQ-010 SHALL have port retire_t_old, input, TW: the previous mapping of the retiring destination; 0 means no destination.
REQ-011 SHALL have port interrupt, input, 1: squash all speculative allocations.
REQ-012 SHALL have port free_count, output, TW: number of free tags, range 0..D.
REQ-013 SHALL have port overflow_err, output, 1: sticky flag set on a push into a full list.

Function
REQ-014 SHALL store entries in a D-entry circular buffer with pointers head, tail and arch_head; each pointer is log2(D)+1 bits, including a wrap bit.
REQ-015 SHALL compute free_count = tail - head as a modulo-2^(log2(D)+1) difference; alloc_valid, alloc_tag and free_count SHALL be driven from registered state only, with no same-cycle bypass.
REQ-016 SHALL, when alloc_en && alloc_valid && !interrupt, advance head by 1 on the next edge; when alloc_en is asserted with alloc_valid low, the request SHALL be ignored with no state change.
REQ-017 SHALL, when retire_en && retire_t_old != 0 and the list is not full, write retire_t_old at tail and advance tail by 1, regardless of interrupt.
REQ-018 SHALL, when retire_en && retire_t_old != 0, advance arch_head by 1, because the retiring instruction's own tag was allocated at arch_head.
REQ-019 SHALL, when retire_en && retire_t_old == 0, leave tail and arch_head unchanged.
REQ-020 SHALL, when retire_en and a push occurs with free_count == D, drop the push, set overflow_err, and leave it set until reset.
REQ-021 SHALL, when interrupt is asserted, load head with the next-state value of arch_head (including any retire advance in the same cycle) and ignore alloc_en.
REQ-022 SHALL, on simultaneous alloc and push in a non-empty list, apply both, leaving free_count unchanged.
REQ-023 SHALL, on simultaneous alloc and push in an empty list, reject the alloc because alloc_valid = 0, apply the push, and make free_count = 1 next cycle.
REQ-024 SHALL wrap all pointers naturally at D; entry index = pointer[log2(D)-1:0].
REQ-025 SHALL never emit tag 0 or any tag below N_ARCH before it has been pushed.

Reset
REQ-026 SHALL, while reset is low, asynchronously set head = 0, arch_head = 0, tail = D (wrap bit 1, index 0) and overflow_err = 0.
REQ-027 SHALL, while reset is low, set entry[i] = N_ARCH + i for i = 0..D-1.
REQ-028 SHALL, after reset, present alloc_valid = 1, alloc_tag = 32 and free_count = 32.
REQ-029 SHALL, when reset asserts mid-operation, discard all in-flight alloc, retire and interrupt effects.

Verification
REQ-030 Reset then 32 consecutive alloc_en cycles -> alloc_tag sequence 32..63; free_count = 0 and alloc_valid = 0 after the last; a 33rd alloc_en causes no change.
REQ-031 Empty list, retire_en with retire_t_old = 5, plus alloc_en in the same cycle -> next cycle free_count = 1, alloc_tag = 5; the alloc is not accepted.
REQ-032 Alloc 3 tags (32, 33, 34), retire 1 with t_old = 7, then interrupt -> head = arch_head = 1, free_count = 32, alloc_tag = 33; tags 33 and 34 are reclaimed.
REQ-033 Interrupt asserted in the same cycle as retire_en with t_old = 9 -> tail advances, entry holds 9, and head equals the post-increment arch_head.
REQ-034 Full list (just after reset), retire_en with t_old = 12 -> overflow_err = 1, free_count stays 32, and overflow_err holds until reset.
REQ-035 retire_en with t_old = 0 -> no pointer changes; reset pulse mid-stream -> all outputs return to the REQ-028 values immediately.
